// File: rtl/wb_gfx_pkg.sv
// Shared register map and bit positions for the graphics command port.
package wb_gfx_pkg;

    typedef enum logic [1:0] {
        REG_CMD      = 2'd0,
        REG_STATUS   = 2'd1,
        REG_CTRL     = 2'd2,
        REG_POPCOUNT = 2'd3
    } reg_sel_e;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_VALID     = 3;
    localparam int STAT_LEVEL_LSB = 8;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;

endpackage

// File: rtl/gfx_cmd_fifo.sv
// Synchronous word FIFO with register storage and a combinational head read.
module gfx_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [31:0]   data_in,
    output logic [31:0]   data_out,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // The extra pointer bit distinguishes a full wrap from an empty FIFO.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign data_out = mem[rd_ptr[AW-1:0]];
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && do_push) mem[wr_ptr[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/wb_gfx_cmd_port.sv
// Wishbone responder queueing CPU command words and streaming them to the graphics engine.
module wb_gfx_cmd_port
    import wb_gfx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0300_0010,
    parameter int          DEPTH        = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_cmd_valid,
    output logic [31:0] o_cmd_data,
    input  logic        i_cmd_ready
);

    localparam int AW = $clog2(DEPTH);

    reg_sel_e    sel;
    logic        hit;
    logic        wr_hit;
    logic        push_req;
    logic        flush_req;
    logic        handshake;
    logic        enable;
    logic        overflow;
    logic [31:0] popcount;
    logic        fifo_empty;
    logic        fifo_full;
    logic [AW:0] fifo_level;
    logic [31:0] status_word;
    logic [31:0] read_word;

    // A pending ack masks the still-held strobe so each transaction acks once.
    assign sel       = reg_sel_e'(i_wb_addr[3:2]);
    assign hit       = i_wb_cyc && i_wb_stb && !o_wb_ack
                       && (i_wb_addr[31:4] == BASE_ADDRESS[31:4]);
    assign wr_hit    = hit && i_wb_we;
    assign push_req  = wr_hit && (sel == REG_CMD);
    assign flush_req = wr_hit && (sel == REG_CTRL) && i_wb_data[CTRL_FLUSH];
    assign o_cmd_valid = enable && !fifo_empty;
    assign handshake   = o_cmd_valid && i_cmd_ready;

    gfx_cmd_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push_req),
        .pop      (handshake),
        .flush    (flush_req),
        .data_in  (i_wb_data),
        .data_out (o_cmd_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .level    (fifo_level)
    );

    always_comb begin
        status_word = '0;
        status_word[STAT_EMPTY]    = fifo_empty;
        status_word[STAT_FULL]     = fifo_full;
        status_word[STAT_OVERFLOW] = overflow;
        status_word[STAT_VALID]    = o_cmd_valid;
        status_word[STAT_LEVEL_LSB +: 8] = 8'(fifo_level);
    end

    always_comb begin
        read_word = '0;
        case (sel)
            REG_STATUS:   read_word = status_word;
            REG_CTRL:     read_word[CTRL_ENABLE] = enable;
            REG_POPCOUNT: read_word = popcount;
            default:      read_word = '0;
        endcase
    end

    // A POPCOUNT write is placed after the increment so clearing beats a same-edge pop.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
            enable    <= 1'b0;
            overflow  <= 1'b0;
            popcount  <= '0;
        end else begin
            o_wb_ack  <= hit;
            o_wb_data <= hit ? read_word : '0;
            if (handshake)
                popcount <= popcount + 32'd1;
            if (wr_hit && (sel == REG_POPCOUNT))
                popcount <= '0;
            if (wr_hit && (sel == REG_CTRL))
                enable <= i_wb_data[CTRL_ENABLE];
            if (push_req && fifo_full && !flush_req)
                overflow <= 1'b1;
            else if (wr_hit && (sel == REG_STATUS) && i_wb_data[STAT_OVERFLOW])
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_gfx_cmd_port.sv
// Scoreboard bench: expected read data and stream words are queued; a monitor compares them.
module tb_wb_gfx_cmd_port;

    localparam logic [31:0] ADDR_CMD    = 32'h0300_0010;
    localparam logic [31:0] ADDR_STATUS = 32'h0300_0014;
    localparam logic [31:0] ADDR_CTRL   = 32'h0300_0018;
    localparam logic [31:0] ADDR_POP    = 32'h0300_001C;
    localparam logic [31:0] ADDR_MISS   = 32'h0300_0020;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0] i_wb_addr, i_wb_data;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;
    logic        o_cmd_valid;
    logic [31:0] o_cmd_data;
    logic        i_cmd_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] rd_q[$];
    logic [31:0] stream_q[$];

    wb_gfx_cmd_port #(.BASE_ADDRESS(32'h0300_0010), .DEPTH(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_wb_cyc    (i_wb_cyc),
        .i_wb_stb    (i_wb_stb),
        .i_wb_we     (i_wb_we),
        .i_wb_addr   (i_wb_addr),
        .i_wb_data   (i_wb_data),
        .o_wb_ack    (o_wb_ack),
        .o_wb_data   (o_wb_data),
        .o_cmd_valid (o_cmd_valid),
        .o_cmd_data  (o_cmd_data),
        .i_cmd_ready (i_cmd_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read ack or a stream handshake.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (o_wb_ack && !i_wb_we) begin
                if (rd_q.size() == 0) checkOutput("unexpected read ack", o_wb_data, 32'hXXXX_XXXX);
                else checkOutput("wb read data", o_wb_data, rd_q.pop_front());
            end
            if (o_cmd_valid && i_cmd_ready) begin
                if (stream_q.size() == 0) checkOutput("unexpected handshake", o_cmd_data, 32'hXXXX_XXXX);
                else checkOutput("stream word", o_cmd_data, stream_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; holds the strobe one extra cycle to prove a single ack.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                                 input string name);
        logic got;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we; i_wb_addr = addr; i_wb_data = data;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (o_wb_ack) got = 1'b1;
        end
        checkOutput({name, " ack"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        checkOutput({name, " single ack"}, 32'(o_wb_ack), 32'd0);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    endtask

    task automatic wbWrite(input logic [31:0] addr, input logic [31:0] data, input string name);
        applyStimulus(1'b1, addr, data, name);
    endtask

    task automatic wbRead(input logic [31:0] addr, input logic [31:0] exp, input string name);
        rd_q.push_back(exp);
        applyStimulus(1'b0, addr, 32'h0, name);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        resetn = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        i_wb_addr = '0; i_wb_data = '0; i_cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ack", 32'(o_wb_ack), 32'd0);
        checkOutput("reset rdata", o_wb_data, 32'd0);
        checkOutput("reset valid", 32'(o_cmd_valid), 32'd0);
        resetn = 1'b1;
        waitCycles(1);

        $display("[TB] basic flow");
        i_cmd_ready = 1'b1;
        wbWrite(ADDR_CTRL, 32'h1, "ctrl enable");
        stream_q.push_back(32'hA5A5_0001);
        wbWrite(ADDR_CMD, 32'hA5A5_0001, "cmd push");
        waitCycles(3);
        wbRead(ADDR_POP, 32'd1, "popcount 1");
        wbRead(ADDR_STATUS, 32'h0000_0001, "status empty");

        $display("[TB] fill and overflow");
        wbWrite(ADDR_CTRL, 32'h0, "ctrl disable");
        for (int i = 0; i < 17; i++) begin
            if (i < 16) stream_q.push_back(32'(i));
            wbWrite(ADDR_CMD, 32'(i), "fill push");
        end
        wbRead(ADDR_STATUS, 32'h0000_1006, "status full overflow");
        wbWrite(ADDR_CTRL, 32'h1, "ctrl enable drain");
        waitCycles(20);
        checkOutput("fill drained", 32'(stream_q.size()), 32'd0);
        wbRead(ADDR_STATUS, 32'h0000_0005, "status sticky overflow");
        wbWrite(ADDR_STATUS, 32'h4, "clear overflow");
        wbRead(ADDR_STATUS, 32'h0000_0001, "status cleared");
        wbRead(ADDR_POP, 32'd17, "popcount 17");

        $display("[TB] backpressure");
        i_cmd_ready = 1'b0;
        stream_q.push_back(32'h0000_0011);
        stream_q.push_back(32'h0000_0022);
        wbWrite(ADDR_CMD, 32'h0000_0011, "bp push1");
        wbWrite(ADDR_CMD, 32'h0000_0022, "bp push2");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp valid held", 32'(o_cmd_valid), 32'd1);
            checkOutput("bp data held", o_cmd_data, 32'h0000_0011);
        end
        @(posedge clk); #1;
        i_cmd_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp hs1 valid", 32'(o_cmd_valid), 32'd1);
        @(negedge clk);
        checkOutput("bp hs2 valid", 32'(o_cmd_valid), 32'd1);
        checkOutput("bp hs2 data", o_cmd_data, 32'h0000_0022);
        @(negedge clk);
        checkOutput("bp drained", 32'(o_cmd_valid), 32'd0);
        @(posedge clk); #1;

        $display("[TB] flush with pop");
        i_cmd_ready = 1'b0;
        wbWrite(ADDR_CMD, 32'h0000_0033, "fl push1");
        wbWrite(ADDR_CMD, 32'h0000_0044, "fl push2");
        stream_q.push_back(32'h0000_0033);
        i_cmd_ready = 1'b1;
        wbWrite(ADDR_CTRL, 32'h3, "flush during pop");
        wbRead(ADDR_POP, 32'd20, "popcount after flush");
        wbRead(ADDR_STATUS, 32'h0000_0001, "status after flush");

        $display("[TB] push into full during pop");
        i_cmd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            stream_q.push_back(32'h100 + 32'(i));
            wbWrite(ADDR_CMD, 32'h100 + 32'(i), "full push");
        end
        i_cmd_ready = 1'b1;
        wbWrite(ADDR_CMD, 32'h0000_DEAD, "push while full and pop");
        waitCycles(20);
        wbRead(ADDR_STATUS, 32'h0000_0005, "status overflow after drop");
        wbRead(ADDR_POP, 32'd36, "popcount 36");
        wbWrite(ADDR_STATUS, 32'h4, "clear overflow 2");

        $display("[TB] address decode");
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
        i_wb_addr = ADDR_MISS; i_wb_data = 32'h0000_0077;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (o_wb_ack) seen = 1'b1;
        end
        checkOutput("miss no ack", 32'(seen), 32'd0);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        wbRead(ADDR_STATUS, 32'h0000_0001, "status after miss");
        wbRead(ADDR_POP, 32'd36, "popcount after miss");
        wbWrite(ADDR_POP, 32'h1234_5678, "popcount clear");
        wbRead(ADDR_POP, 32'd0, "popcount cleared");

        $display("[TB] reset mid-operation");
        i_cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) wbWrite(ADDR_CMD, 32'h200 + 32'(i), "queue push");
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = ADDR_STATUS;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        checkOutput("mid reset ack", 32'(o_wb_ack), 32'd0);
        checkOutput("mid reset valid", 32'(o_cmd_valid), 32'd0);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        waitCycles(1);
        wbRead(ADDR_STATUS, 32'h0000_0001, "status after reset");
        wbRead(ADDR_CTRL, 32'h0000_0000, "ctrl after reset");

        waitCycles(4);
        checkOutput("read queue drained", 32'(rd_q.size()), 32'd0);
        checkOutput("stream queue drained", 32'(stream_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
